// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register with load-use stall detection, bubble insertion and bubble counter
module id_ex_register (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_RegWrite,
    input  logic [1:0]  id_MemWrite,
    input  logic [4:0]  id_AluOpcode,
    input  logic [2:0]  id_JumpSignal,
    input  logic        id_AluSrcASignal,
    input  logic        id_AluSrcBSignal,
    input  logic [1:0]  id_WriteRegDataSignal,
    input  logic [1:0]  id_WriteRegSignal,
    input  logic [2:0]  id_MemRead,
    input  logic [31:0] id_pc_plus4,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm_ext,
    input  logic [4:0]  id_shamt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_valid,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        flush,
    input  logic        hold,
    output logic        ex_RegWrite,
    output logic [1:0]  ex_MemWrite,
    output logic [4:0]  ex_AluOpcode,
    output logic [2:0]  ex_JumpSignal,
    output logic        ex_AluSrcASignal,
    output logic        ex_AluSrcBSignal,
    output logic [1:0]  ex_WriteRegDataSignal,
    output logic [1:0]  ex_WriteRegSignal,
    output logic [2:0]  ex_MemRead,
    output logic [31:0] ex_pc_plus4,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm_ext,
    output logic [4:0]  ex_shamt,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic        ex_valid,
    output logic [4:0]  ex_dest,
    output logic        load_use_stall,
    output logic [15:0] bubble_cnt
);
    logic [19:0]  ctrl_q;
    logic [148:0] data_q;
    logic         bubble;
    assign {ex_RegWrite, ex_MemWrite, ex_AluOpcode, ex_JumpSignal, ex_AluSrcASignal, ex_AluSrcBSignal,
            ex_WriteRegDataSignal, ex_WriteRegSignal, ex_MemRead} = ctrl_q;
    assign {ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext, ex_shamt, ex_rs, ex_rt, ex_rd, ex_valid} = data_q;
    assign ex_dest = ex_WriteRegSignal == 2'b00 ? ex_rt :
                     ex_WriteRegSignal == 2'b01 ? ex_rd :
                     ex_WriteRegSignal == 2'b10 ? 5'd31 : 5'd0;
    // flush squashes the ID instruction anyway, so it masks the stall
    assign load_use_stall = ex_valid & (ex_MemRead != 3'd0) & ex_RegWrite & (ex_dest != 5'd0) &
                            ((id_uses_rs & (id_rs == ex_dest)) | (id_uses_rt & (id_rt == ex_dest))) &
                            id_valid & ~flush;
    assign bubble = flush | load_use_stall;
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            data_q     <= '0;
            bubble_cnt <= '0;
        end else if (!hold) begin
            ctrl_q <= (bubble || !id_valid) ? '0 :
                      {id_RegWrite, id_MemWrite, id_AluOpcode, id_JumpSignal, id_AluSrcASignal, id_AluSrcBSignal,
                       id_WriteRegDataSignal, id_WriteRegSignal, id_MemRead};
            data_q <= bubble ? '0 :
                      {id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext, id_shamt, id_rs, id_rt, id_rd, id_valid};
            if (bubble && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: randomized and directed checks of id_ex_register against a field-level model
module tb_id_ex_register;
    typedef struct packed {
        logic        RegWrite;
        logic [1:0]  MemWrite;
        logic [4:0]  AluOpcode;
        logic [2:0]  JumpSignal;
        logic        AluSrcA;
        logic        AluSrcB;
        logic [1:0]  WrData;
        logic [1:0]  WrReg;
        logic [2:0]  MemRead;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        valid;
    } ex_t;

    logic clk, rst, flush, hold, uses_rs, uses_rt;
    ex_t  id, m, dut_ex;
    logic [15:0] m_cnt;
    int checks = 0, errors = 0;

    logic        ex_RegWrite, ex_AluSrcASignal, ex_AluSrcBSignal, ex_valid, load_use_stall;
    logic [1:0]  ex_MemWrite, ex_WriteRegDataSignal, ex_WriteRegSignal;
    logic [4:0]  ex_AluOpcode, ex_shamt, ex_rs, ex_rt, ex_rd, ex_dest;
    logic [2:0]  ex_JumpSignal, ex_MemRead;
    logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
    logic [15:0] bubble_cnt;

    id_ex_register dut (
        .clk(clk), .rst(rst),
        .id_RegWrite(id.RegWrite), .id_MemWrite(id.MemWrite), .id_AluOpcode(id.AluOpcode),
        .id_JumpSignal(id.JumpSignal), .id_AluSrcASignal(id.AluSrcA), .id_AluSrcBSignal(id.AluSrcB),
        .id_WriteRegDataSignal(id.WrData), .id_WriteRegSignal(id.WrReg), .id_MemRead(id.MemRead),
        .id_pc_plus4(id.pc), .id_rs_data(id.rs_data), .id_rt_data(id.rt_data), .id_imm_ext(id.imm),
        .id_shamt(id.shamt), .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd), .id_valid(id.valid),
        .id_uses_rs(uses_rs), .id_uses_rt(uses_rt), .flush(flush), .hold(hold),
        .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_AluOpcode(ex_AluOpcode),
        .ex_JumpSignal(ex_JumpSignal), .ex_AluSrcASignal(ex_AluSrcASignal), .ex_AluSrcBSignal(ex_AluSrcBSignal),
        .ex_WriteRegDataSignal(ex_WriteRegDataSignal), .ex_WriteRegSignal(ex_WriteRegSignal),
        .ex_MemRead(ex_MemRead), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm_ext(ex_imm_ext), .ex_shamt(ex_shamt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .ex_dest(ex_dest), .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
    );

    assign dut_ex = {ex_RegWrite, ex_MemWrite, ex_AluOpcode, ex_JumpSignal, ex_AluSrcASignal, ex_AluSrcBSignal,
                     ex_WriteRegDataSignal, ex_WriteRegSignal, ex_MemRead, ex_pc_plus4, ex_rs_data, ex_rt_data,
                     ex_imm_ext, ex_shamt, ex_rs, ex_rt, ex_rd, ex_valid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] m_dest();
        case (m.WrReg)
            2'b00:   return m.rt;
            2'b01:   return m.rd;
            2'b10:   return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic m_stall();
        logic [4:0] d;
        d = m_dest();
        return m.valid && m.MemRead != 0 && m.RegWrite && d != 0 &&
               ((uses_rs && id.rs == d) || (uses_rt && id.rt == d)) && id.valid && !flush;
    endfunction

    // Advance one clock edge and apply the register's rules to the model
    task automatic tick();
        logic s;
        s = m_stall();
        @(posedge clk);
        if (rst) begin
            m = '0;
            m_cnt = 16'd0;
        end else if (!hold) begin
            if (flush || s) begin
                m = '0;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else begin
                m = id;
                if (!id.valid) begin
                    m.RegWrite = 0; m.MemWrite = 0; m.AluOpcode = 0; m.JumpSignal = 0; m.AluSrcA = 0;
                    m.AluSrcB = 0; m.WrData = 0; m.WrReg = 0; m.MemRead = 0;
                end
            end
        end
        #1;
    endtask

    task automatic rand_id();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        id = r[168:0];
        uses_rs = r[169];
        uses_rt = r[170];
    endtask

    task automatic load_lw(input logic [4:0] rt);
        id = '0;
        id.RegWrite = 1'b1; id.MemRead = 3'b001; id.WrReg = 2'b00; id.rt = rt; id.valid = 1'b1;
        uses_rs = 1'b0; uses_rt = 1'b0; flush = 1'b0; hold = 1'b0; rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rand_id();
        rst = 1'b1; hold = 1'b1; flush = 1'($urandom);
        tick();
        checks++;
        if (dut_ex !== '0 || bubble_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got %h cnt %h exp 0 cnt 0", dut_ex, bubble_cnt);
        end
        rst = 1'b0; hold = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got %b exp 0", load_use_stall);
        end
    endtask

    task automatic test_pass_through();
        id = '0;
        id.AluOpcode = 5'h01; id.RegWrite = 1'b1; id.rs = 5'd3; id.rt = 5'd4; id.rd = 5'd5;
        id.rs_data = 32'h11; id.rt_data = 32'h22; id.WrReg = 2'b01; id.valid = 1'b1; id.pc = 32'h104;
        uses_rs = 1'b1; uses_rt = 1'b1; flush = 1'b0; hold = 1'b0; rst = 1'b0;
        tick();
        checks++;
        if (dut_ex !== id || ex_valid !== 1'b1 || ex_dest !== 5'd5) begin
            errors++;
            $display("FAIL pass_through got %h dest %0d exp %h dest 5", dut_ex, ex_dest, id);
        end
    endtask

    task automatic test_load_use();
        logic [15:0] c0;
        c0 = m_cnt;
        load_lw(5'd8);
        checks++;
        if (ex_dest !== 5'd8) begin
            errors++;
            $display("FAIL lw_dest got %0d exp 8", ex_dest);
        end
        rand_id();
        id.valid = 1'b1; id.rs = 5'd8; uses_rs = 1'b1; uses_rt = 1'b0;
        #1;
        checks++;
        if (load_use_stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall got %b exp 1", load_use_stall);
        end
        tick();
        checks++;
        if (dut_ex !== '0 || bubble_cnt !== c0 + 16'd1) begin
            errors++;
            $display("FAIL load_use_bubble got %h cnt %h exp 0 cnt %h", dut_ex, bubble_cnt, c0 + 16'd1);
        end
        checks++;
        if (load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_one_cycle got %b exp 0", load_use_stall);
        end
        tick();
        checks++;
        if (dut_ex !== m || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_use_reissue got %h exp %h", dut_ex, m);
        end
    endtask

    task automatic test_no_false_stall();
        load_lw(5'd0);
        rand_id();
        id.valid = 1'b1; id.rs = 5'd0; uses_rs = 1'b1;
        #1;
        checks++;
        if (load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL no_stall_dest0 got %b exp 0", load_use_stall);
        end
        tick();
        checks++;
        if (dut_ex !== m || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL capture_dest0 got %h exp %h", dut_ex, m);
        end
        load_lw(5'd8);
        rand_id();
        id.valid = 1'b1; id.rs = 5'd8; uses_rs = 1'b0; uses_rt = 1'b0;
        #1;
        checks++;
        if (load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL no_stall_unused got %b exp 0", load_use_stall);
        end
        tick();
        checks++;
        if (dut_ex !== m || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL capture_unused got %h exp %h", dut_ex, m);
        end
    endtask

    task automatic test_flush_hazard();
        logic [15:0] c0;
        load_lw(5'd8);
        c0 = m_cnt;
        rand_id();
        id.valid = 1'b1; id.rt = 5'd8; uses_rt = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_masks_stall got %b exp 0", load_use_stall);
        end
        tick();
        checks++;
        if (dut_ex !== '0 || bubble_cnt !== c0 + 16'd1) begin
            errors++;
            $display("FAIL flush_bubble got %h cnt %h exp 0 cnt %h", dut_ex, bubble_cnt, c0 + 16'd1);
        end
        flush = 1'b0;
    endtask

    task automatic test_hold();
        ex_t e;
        logic [15:0] c;
        rand_id();
        id.valid = 1'b1; uses_rs = 1'b0; uses_rt = 1'b0; flush = 1'b0; hold = 1'b0;
        tick();
        e = m;
        c = m_cnt;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            hold = 1'b1; flush = 1'b1;
            tick();
            checks++;
            if (dut_ex !== e || bubble_cnt !== c) begin
                errors++;
                $display("FAIL hold_%0d got %h cnt %h exp %h cnt %h", i, dut_ex, bubble_cnt, e, c);
            end
        end
        rand_id();
        uses_rs = 1'b0; uses_rt = 1'b0; hold = 1'b0; flush = 1'b0;
        tick();
        checks++;
        if (dut_ex !== m || bubble_cnt !== c) begin
            errors++;
            $display("FAIL hold_release got %h cnt %h exp %h cnt %h", dut_ex, bubble_cnt, m, c);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_id();
            id.rs = 5'($urandom_range(0, 3));
            id.rt = 5'($urandom_range(0, 3));
            id.rd = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) id.MemRead = 3'd0;
            if ($urandom_range(0, 3) != 0) id.valid = 1'b1;
            rst   = ($urandom_range(0, 49) == 0);
            hold  = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            #1;
            checks++;
            if (load_use_stall !== m_stall()) begin
                errors++;
                $display("FAIL rand_stall_%0d got %b exp %b", i, load_use_stall, m_stall());
            end
            tick();
            checks++;
            if (dut_ex !== m || bubble_cnt !== m_cnt || ex_dest !== m_dest()) begin
                errors++;
                $display("FAIL rand_state_%0d got %h cnt %h dest %0d exp %h cnt %h dest %0d",
                         i, dut_ex, bubble_cnt, ex_dest, m, m_cnt, m_dest());
            end
        end
        rst = 1'b0; hold = 1'b0; flush = 1'b0;
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b1; hold = 1'b0;
        repeat (65534) tick();
        checks++;
        if (bubble_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_preload got %h exp fffe", bubble_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bubble_cnt !== 16'hFFFF) begin
                errors++;
                $display("FAIL sat_%0d got %h exp ffff", i, bubble_cnt);
            end
        end
        rand_id();
        id.valid = 1'b1; flush = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0;
        tick();
        rand_id();
        rst = 1'b1; hold = 1'b1;
        tick();
        checks++;
        if (dut_ex !== '0 || bubble_cnt !== 16'd0 || load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_hold got %h cnt %h stall %b exp 0", dut_ex, bubble_cnt, load_use_stall);
        end
        rst = 1'b0; hold = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0;
        id = '0; m = '0; m_cnt = 16'd0;
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_false_stall();
        test_flush_hazard();
        test_hold();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
